// File: rtl/overture_pkg.sv
// Shared types for the OVERTURE sequencer: opcode classes, ALU ops,
// condition codes, IO index and sequencer state.
package overture_pkg;

    localparam logic [2:0] IO_INDEX  = 3'd6;
    localparam logic [2:0] BAD_INDEX = 3'd7;

    typedef enum logic [1:0] {
        CLS_IMM  = 2'b00,
        CLS_CALC = 2'b01,
        CLS_COPY = 2'b10,
        CLS_COND = 2'b11
    } op_class_e;

    typedef enum logic [2:0] {
        ALU_OR   = 3'd0,
        ALU_NAND = 3'd1,
        ALU_NOR  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        CC_NEVER  = 3'd0,
        CC_EQ     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_ALWAYS = 3'd4,
        CC_NE     = 3'd5,
        CC_GE     = 3'd6,
        CC_GT     = 3'd7
    } cond_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } seq_state_e;

    function automatic logic alu_op_legal(input logic [2:0] op);
        return op <= 3'(ALU_SUB);
    endfunction

endpackage

// File: rtl/overture_cond_eval.sv
// Jump condition evaluator: compares a signed value against zero per cond code.
module overture_cond_eval
    import overture_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]            cond,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  taken
);

    logic zero;
    logic neg;

    assign zero = (value == '0);
    assign neg  = value[DATA_WIDTH-1];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            CC_NEVER:  taken = 1'b0;
            CC_EQ:     taken = zero;
            CC_LT:     taken = neg;
            CC_LE:     taken = neg | zero;
            CC_ALWAYS: taken = 1'b1;
            CC_NE:     taken = ~zero;
            CC_GE:     taken = ~neg;
            CC_GT:     taken = ~neg & ~zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_seq.sv
// OVERTURE instruction sequencer: two-state fetch/exec machine that owns the
// pc and drives datapath strobes decoded combinationally from the held ir.
module overture_seq
    import overture_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic [DATA_WIDTH-1:0] reg0_val,
    input  logic [DATA_WIDTH-1:0] reg3_val,
    output logic [5:0]            imm_val,
    output logic                  imm_we,
    output logic [2:0]            alu_op,
    output logic                  alu_we,
    output logic [2:0]            cp_src,
    output logic [2:0]            cp_dst,
    output logic                  cp_we,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  illegal,
    output logic                  retire,
    output logic [PC_WIDTH-1:0]   pc
);

    seq_state_e            state;
    logic [DATA_WIDTH-1:0] ir;
    op_class_e             cls;
    logic [2:0]            src;
    logic [2:0]            dst;
    logic                  cp_bad;
    logic                  need_in;
    logic                  need_out;
    logic                  cond_taken;
    logic                  done;
    logic                  jump;

    assign cls      = op_class_e'(ir[7:6]);
    assign src      = ir[5:3];
    assign dst      = ir[2:0];
    assign cp_bad   = (src == BAD_INDEX) || (dst == BAD_INDEX);
    assign need_in  = (src == IO_INDEX);
    assign need_out = (dst == IO_INDEX);

    // Gated by rst so an in-flight request drops as soon as reset is asserted.
    assign imem_req  = (state == ST_FETCH) && rst;
    assign imem_addr = pc;

    overture_cond_eval #(.DATA_WIDTH(DATA_WIDTH)) u_cond (
        .cond  (ir[2:0]),
        .value (reg3_val),
        .taken (cond_taken)
    );

    always_comb begin
        imm_val   = '0;
        imm_we    = 1'b0;
        alu_op    = '0;
        alu_we    = 1'b0;
        cp_src    = '0;
        cp_dst    = '0;
        cp_we     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        illegal   = 1'b0;
        done      = 1'b0;
        jump      = 1'b0;
        if (state == ST_EXEC) begin
            case (cls)
                CLS_IMM: begin
                    imm_val = ir[5:0];
                    imm_we  = 1'b1;
                    done    = 1'b1;
                end
                CLS_CALC: begin
                    alu_op  = ir[2:0];
                    alu_we  = alu_op_legal(ir[2:0]);
                    illegal = ~alu_op_legal(ir[2:0]);
                    done    = 1'b1;
                end
                CLS_COPY: begin
                    cp_src = src;
                    cp_dst = dst;
                    if (cp_bad) begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end else begin
                        // IO-to-IO copy only hands off when both ends are ready.
                        in_ready  = need_in  && (!need_out || out_ready);
                        out_valid = need_out && (!need_in  || in_valid);
                        cp_we     = (!need_in || in_valid) && (!need_out || out_ready);
                        done      = cp_we;
                    end
                end
                CLS_COND: begin
                    jump = cond_taken;
                    done = 1'b1;
                end
                default: done = 1'b1;
            endcase
        end
        retire = done;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (done) begin
                        pc    <= jump ? PC_WIDTH'(reg0_val) : pc + PC_WIDTH'(1);
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_overture_seq.sv
// Directed bench for overture_seq: drives a zero-wait memory model and IO
// handshakes, checking strobes and pc against hand-computed values.
module tb_overture_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_rdata = '0;
    logic [7:0] reg0_val = '0;
    logic [7:0] reg3_val = '0;
    logic [5:0] imm_val;
    logic       imm_we;
    logic [2:0] alu_op;
    logic       alu_we;
    logic [2:0] cp_src;
    logic [2:0] cp_dst;
    logic       cp_we;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       illegal;
    logic       retire;
    logic [7:0] pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    overture_seq #(.PC_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .reg0_val(reg0_val), .reg3_val(reg3_val),
        .imm_val(imm_val), .imm_we(imm_we), .alu_op(alu_op), .alu_we(alu_we),
        .cp_src(cp_src), .cp_dst(cp_dst), .cp_we(cp_we),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .illegal(illegal), .retire(retire), .pc(pc)
    );

    // Zero-wait fetch: acks in the request cycle, returns sampled req/addr,
    // and leaves the caller in the EXEC cycle just after the falling edge.
    task automatic fetch(input logic [7:0] instr, output logic req_o, output logic [7:0] addr_o);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = instr;
        #1; req_o = imem_req; addr_o = imem_addr;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (retire !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", retire); end
        checks++; if (imm_we !== 1'b0) begin failures++; $display("FAIL reset_imm_we got=%b exp=0", imm_we); end
    endtask

    task automatic test_imm;
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 8'h05;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL imm_first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL imm_first_addr got=%h exp=00", imem_addr); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (imm_we !== 1'b1) begin failures++; $display("FAIL imm_we got=%b exp=1", imm_we); end
        checks++; if (imm_val !== 6'd5) begin failures++; $display("FAIL imm_val got=%h exp=05", imm_val); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL imm_retire got=%b exp=1", retire); end
        @(posedge clk); #1;
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL imm_pc got=%h exp=01", pc); end
        checks++; if (imem_addr !== 8'h01 || imem_req !== 1'b1) begin failures++; $display("FAIL imm_next_fetch got=%h/%b exp=01/1", imem_addr, imem_req); end
    endtask

    task automatic test_calc;
        logic r; logic [7:0] a;
        fetch(8'h44, r, a);
        checks++; if (a !== 8'h01) begin failures++; $display("FAIL calc_addr got=%h exp=01", a); end
        checks++; if (alu_we !== 1'b1) begin failures++; $display("FAIL calc_alu_we got=%b exp=1", alu_we); end
        checks++; if (alu_op !== 3'd4) begin failures++; $display("FAIL calc_alu_op got=%0d exp=4", alu_op); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL calc_illegal got=%b exp=0", illegal); end
        fetch(8'h47, r, a);
        checks++; if (alu_we !== 1'b0) begin failures++; $display("FAIL calc7_alu_we got=%b exp=0", alu_we); end
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL calc7_illegal got=%b exp=1", illegal); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL calc7_retire got=%b exp=1", retire); end
        @(posedge clk); #1;
        checks++; if (pc !== 8'h03) begin failures++; $display("FAIL calc7_pc got=%h exp=03", pc); end
    endtask

    task automatic test_cond;
        logic r; logic [7:0] a;
        reg3_val = 8'h00; reg0_val = 8'h20;
        fetch(8'hC1, r, a);
        checks++; if (a !== 8'h03) begin failures++; $display("FAIL cond_addr got=%h exp=03", a); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL cond_retire got=%b exp=1", retire); end
        @(posedge clk); #1;
        checks++; if (imem_addr !== 8'h20) begin failures++; $display("FAIL cond_eq_taken got=%h exp=20", imem_addr); end
        reg3_val = 8'hFF;
        fetch(8'hC1, r, a);
        @(posedge clk); #1;
        checks++; if (pc !== 8'h21) begin failures++; $display("FAIL cond_eq_not_taken got=%h exp=21", pc); end
        reg3_val = 8'h80; reg0_val = 8'h40;
        fetch(8'hC2, r, a);
        @(posedge clk); #1;
        checks++; if (pc !== 8'h40) begin failures++; $display("FAIL cond_lt_taken got=%h exp=40", pc); end
        fetch(8'hC7, r, a);
        @(posedge clk); #1;
        checks++; if (pc !== 8'h41) begin failures++; $display("FAIL cond_gt_not_taken got=%h exp=41", pc); end
    endtask

    task automatic test_copy_in;
        logic r; logic [7:0] a;
        in_valid = 1'b0;
        fetch(8'hB0, r, a);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cpin_in_ready_stall got=%b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++; if (cp_we !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL cpin_stall%0d cp_we/retire got=%b/%b exp=0/0", i, cp_we, retire); end
            checks++; if (pc !== 8'h41) begin failures++; $display("FAIL cpin_stall%0d_pc got=%h exp=41", i, pc); end
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        checks++; if (cp_we !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL cpin_commit cp_we/in_ready got=%b/%b exp=1/1", cp_we, in_ready); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL cpin_retire got=%b exp=1", retire); end
        checks++; if (cp_src !== 3'd6 || cp_dst !== 3'd0) begin failures++; $display("FAIL cpin_idx got=%0d/%0d exp=6/0", cp_src, cp_dst); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (pc !== 8'h42) begin failures++; $display("FAIL cpin_pc got=%h exp=42", pc); end
    endtask

    task automatic test_copy_io;
        logic r; logic [7:0] a;
        in_valid = 1'b1; out_ready = 1'b0;
        fetch(8'hB6, r, a);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL cpio_stall out_valid/in_ready got=%b/%b exp=1/0", out_valid, in_ready); end
        checks++; if (cp_we !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL cpio_stall cp_we/retire got=%b/%b exp=0/0", cp_we, retire); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (cp_we !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL cpio_commit we/ir/ov got=%b/%b/%b exp=1/1/1", cp_we, in_ready, out_valid); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL cpio_retire got=%b exp=1", retire); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (pc !== 8'h43) begin failures++; $display("FAIL cpio_pc got=%h exp=43", pc); end
    endtask

    task automatic test_copy_illegal;
        logic r; logic [7:0] a;
        fetch(8'hBF, r, a);
        checks++; if (illegal !== 1'b1 || cp_we !== 1'b0 || retire !== 1'b1) begin failures++; $display("FAIL cpbad ill/we/ret got=%b/%b/%b exp=1/0/1", illegal, cp_we, retire); end
        in_valid = 1'b1;
        fetch(8'hB7, r, a);
        checks++; if (in_ready !== 1'b0 || illegal !== 1'b1) begin failures++; $display("FAIL cpbad_dst7 in_ready/ill got=%b/%b exp=0/1", in_ready, illegal); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (pc !== 8'h45) begin failures++; $display("FAIL cpbad_pc got=%h exp=45", pc); end
    endtask

    task automatic test_reset_midfetch;
        logic r; logic [7:0] a;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h45) begin failures++; $display("FAIL rstf_req got=%b/%h exp=1/45", imem_req, imem_addr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstf_req_drop got=%b exp=0", imem_req); end
        @(negedge clk); #1;
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL rstf_pc got=%h exp=00", pc); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 8'h44;
        @(negedge clk);
        imem_ack = 1'b0; rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL rstf_refetch got=%b/%h exp=1/00", imem_req, imem_addr); end
        checks++; if (alu_we !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL rstf_stale_ack alu_we/retire got=%b/%b exp=0/0", alu_we, retire); end
        fetch(8'h01, r, a);
        checks++; if (a !== 8'h00) begin failures++; $display("FAIL rstf_fetch_addr got=%h exp=00", a); end
        checks++; if (imm_we !== 1'b1 || imm_val !== 6'd1) begin failures++; $display("FAIL rstf_imm got=%b/%h exp=1/01", imm_we, imm_val); end
        @(posedge clk); #1;
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL rstf_pc_after got=%h exp=01", pc); end
    endtask

    task automatic test_wrap;
        logic r; logic [7:0] a;
        reg0_val = 8'hFF;
        fetch(8'hC4, r, a);
        @(posedge clk); #1;
        checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL wrap_setup_pc got=%h exp=ff", pc); end
        fetch(8'h3F, r, a);
        checks++; if (a !== 8'hFF || imm_val !== 6'h3F) begin failures++; $display("FAIL wrap_fetch addr/imm got=%h/%h exp=ff/3f", a, imm_val); end
        @(posedge clk); #1;
        checks++; if (pc !== 8'h00 || imem_addr !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h/%h exp=00/00", pc, imem_addr); end
    endtask

    initial begin
        test_reset;
        test_imm;
        test_calc;
        test_cond;
        test_copy_in;
        test_copy_io;
        test_copy_illegal;
        test_reset_midfetch;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
